// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: adds or subtracts two WIDTH-bit operands DIGIT bits per cycle, LSB digit first
module digit_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Subtract,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [DIGIT:0]    ds;
  logic [WIDTH-1:0]  res_next;
  logic              last;
  assign ds       = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
  assign res_next = WIDTH'({ds[DIGIT-1:0], res_q} >> DIGIT);
  assign last     = cnt_q == CW'(N - 1);
  // operands shift down one digit per RUN cycle; result digits enter at the top
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        cnt_d   = '0;
        carry_d = Subtract;
        a_d     = A;
        b_d     = B ^ {WIDTH{Subtract}};
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = ds[DIGIT];
        res_d   = res_next;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          sum_d   = res_next;
          cout_d  = ds[DIGIT];
          ovf_d   = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ ds[DIGIT-1] ^ ds[DIGIT];
          zero_d  = res_next == '0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d == RUN;
    done_d = state_d == DONE;
  end
  // state and registered outputs, reset clears everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;
  assign Zero = zero_q;
endmodule
